// File: rtl/mem_arb_pkg.sv
// Shared types and default geometry for the two-port RAM arbiter.
// Response FSM encoding and default RAM window/starvation limit live here.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RESP_I = 3'd1,
        ST_RESP_D = 3'd2,
        ST_ERR_I  = 3'd3,
        ST_ERR_D  = 3'd4
    } resp_state_t;

    localparam int unsigned MEM_SIZE_DEF     = 8192;
    localparam logic [31:0] MEM_START_DEF    = 32'h0000_0000;
    localparam int unsigned STARVE_LIMIT_DEF = 4;
    localparam int unsigned STARVE_CNT_W     = 4;

endpackage

// File: rtl/mem_addr_decode.sv
// Purpose: flags whether a byte address falls inside the RAM window.
// Latency: purely combinational, zero cycles.
// Backpressure: none; output follows the address every cycle.
module mem_addr_decode #(
    parameter int unsigned MEM_SIZE  = 8192,
    parameter logic [31:0] MEM_START = 32'h0000_0000
) (
    input  logic [31:0] addr,
    output logic        in_range
);

    localparam logic [31:0] ADDR_MASK = ~(MEM_SIZE[31:0] - 32'd1);

    assign in_range = ((addr & ADDR_MASK) == MEM_START);

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: arbitrates core fetch and load/store ports onto one single-port RAM.
// Latency: grant combinational in the request cycle, response one cycle later.
// Backpressure: the losing port sees gnt=0 and must hold its request.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MEM_SIZE     = MEM_SIZE_DEF,
    parameter logic [31:0] MEM_START    = MEM_START_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic        clk_sys,
    input  logic        rst_sys_n,

    input  logic        instr_req_i,
    input  logic [31:0] instr_addr_i,
    output logic        instr_gnt_o,
    output logic        instr_rvalid_o,
    output logic        instr_err_o,
    output logic [31:0] instr_rdata_o,

    input  logic        data_req_i,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic [31:0] data_rdata_o,

    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [STARVE_CNT_W-1:0] STARVE_LIM = STARVE_LIMIT[STARVE_CNT_W-1:0];

    resp_state_t             state_q, state_d;
    logic [STARVE_CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic                    instr_in_range, data_in_range;

    mem_addr_decode #(.MEM_SIZE(MEM_SIZE), .MEM_START(MEM_START)) u_instr_decode (
        .addr     (instr_addr_i),
        .in_range (instr_in_range)
    );

    mem_addr_decode #(.MEM_SIZE(MEM_SIZE), .MEM_START(MEM_START)) u_data_decode (
        .addr     (data_addr_i),
        .in_range (data_in_range)
    );

    // Fetch wins unless data has waited STARVE_LIMIT consecutive fetch grants.
    always_comb begin
        instr_gnt_o = 1'b0;
        data_gnt_o  = 1'b0;
        if (rst_sys_n) begin
            if (data_req_i && (!instr_req_i || starve_cnt_q == STARVE_LIM)) begin
                data_gnt_o = 1'b1;
            end else if (instr_req_i) begin
                instr_gnt_o = 1'b1;
            end
        end
    end

    always_comb begin
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = 4'h0;
        mem_addr_o  = 32'h0;
        mem_wdata_o = 32'h0;
        if (instr_gnt_o && instr_in_range) begin
            mem_req_o  = 1'b1;
            mem_be_o   = 4'hF;
            mem_addr_o = instr_addr_i;
        end else if (data_gnt_o && data_in_range) begin
            mem_req_o   = 1'b1;
            mem_we_o    = data_we_i;
            mem_be_o    = data_be_i;
            mem_addr_o  = data_addr_i;
            mem_wdata_o = data_wdata_i;
        end
    end

    always_comb begin
        state_d      = ST_IDLE;
        starve_cnt_d = starve_cnt_q;
        if (instr_gnt_o) begin
            state_d = instr_in_range ? ST_RESP_I : ST_ERR_I;
        end else if (data_gnt_o) begin
            state_d = data_in_range ? ST_RESP_D : ST_ERR_D;
        end

        if (!data_req_i || data_gnt_o) begin
            starve_cnt_d = '0;
        end else if (instr_gnt_o && starve_cnt_q < STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            state_q      <= ST_IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Response routing: RAM return goes to the port that owned last cycle's grant.
    always_comb begin
        instr_rvalid_o = 1'b0;
        instr_err_o    = 1'b0;
        instr_rdata_o  = 32'h0;
        data_rvalid_o  = 1'b0;
        data_err_o     = 1'b0;
        data_rdata_o   = 32'h0;
        unique case (state_q)
            ST_RESP_I: begin
                instr_rvalid_o = mem_rvalid_i;
                instr_rdata_o  = mem_rdata_i;
            end
            ST_RESP_D: begin
                data_rvalid_o = mem_rvalid_i;
                data_rdata_o  = mem_rdata_i;
            end
            ST_ERR_I: begin
                instr_rvalid_o = 1'b1;
                instr_err_o    = 1'b1;
            end
            ST_ERR_D: begin
                data_rvalid_o = 1'b1;
                data_err_o    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grants, starvation, range errors, reset.
module tb_mem_port_arbiter;

    logic        clk_sys = 1'b0;
    logic        rst_sys_n;
    logic        instr_req_i;
    logic [31:0] instr_addr_i;
    logic        instr_gnt_o, instr_rvalid_o, instr_err_o;
    logic [31:0] instr_rdata_o;
    logic        data_req_i, data_we_i;
    logic [3:0]  data_be_i;
    logic [31:0] data_addr_i, data_wdata_i;
    logic        data_gnt_o, data_rvalid_o, data_err_o;
    logic [31:0] data_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;

    int pass_cnt  = 0;
    int total_cnt = 0;

    always #5 clk_sys = ~clk_sys;

    mem_port_arbiter #(.MEM_SIZE(8192), .MEM_START(32'h0), .STARVE_LIMIT(4)) dut (
        .clk_sys        (clk_sys),
        .rst_sys_n      (rst_sys_n),
        .instr_req_i    (instr_req_i),
        .instr_addr_i   (instr_addr_i),
        .instr_gnt_o    (instr_gnt_o),
        .instr_rvalid_o (instr_rvalid_o),
        .instr_err_o    (instr_err_o),
        .instr_rdata_o  (instr_rdata_o),
        .data_req_i     (data_req_i),
        .data_we_i      (data_we_i),
        .data_be_i      (data_be_i),
        .data_addr_i    (data_addr_i),
        .data_wdata_i   (data_wdata_i),
        .data_gnt_o     (data_gnt_o),
        .data_rvalid_o  (data_rvalid_o),
        .data_err_o     (data_err_o),
        .data_rdata_o   (data_rdata_o),
        .mem_req_o      (mem_req_o),
        .mem_we_o       (mem_we_o),
        .mem_be_o       (mem_be_o),
        .mem_addr_o     (mem_addr_o),
        .mem_wdata_o    (mem_wdata_o),
        .mem_rvalid_i   (mem_rvalid_i),
        .mem_rdata_i    (mem_rdata_i)
    );

    // Step to just after the next rising edge; inputs change here, outputs settle by +1.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle_inputs();
        instr_req_i  = 1'b0;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b0;
        data_we_i    = 1'b0;
        data_be_i    = 4'h0;
        data_addr_i  = 32'h0;
        data_wdata_i = 32'h0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = 32'h0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_sys_n    = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        mem_rvalid_i = 1'b1;
        tick();
        #1;
        total_cnt++;
        if (instr_gnt_o !== 1'b0 || mem_req_o !== 1'b0) $display("FAIL reset_gnt: gnt=%b mem_req=%b required 0/0", instr_gnt_o, mem_req_o);
        else pass_cnt++;
        total_cnt++;
        if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0) $display("FAIL reset_rvalid: i=%b d=%b required 0/0", instr_rvalid_o, data_rvalid_o);
        else pass_cnt++;
        idle_inputs();
        tick();
        rst_sys_n = 1'b1;
        tick();
    endtask

    task automatic test_instr_fetch();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h80;
        data_wdata_i = 32'hA5A5_A5A5;
        #1;
        total_cnt++;
        if (instr_gnt_o !== 1'b1 || data_gnt_o !== 1'b0 || mem_req_o !== 1'b1)
            $display("FAIL fetch_gnt: igIt=%b dg=%b mem_req=%b required 1/0/1", instr_gnt_o, data_gnt_o, mem_req_o);
        else pass_cnt++;
        total_cnt++;
        if (mem_addr_o !== 32'h80 || mem_we_o !== 1'b0 || mem_be_o !== 4'hF || mem_wdata_o !== 32'h0)
            $display("FAIL fetch_fields: addr=%h we=%b be=%h wdata=%h required 80/0/f/0", mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o);
        else pass_cnt++;
        tick();
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hDEAD_BEEF;
        #1;
        total_cnt++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'hDEAD_BEEF || instr_err_o !== 1'b0 || data_rvalid_o !== 1'b0)
            $display("FAIL fetch_resp: rv=%b rdata=%h err=%b drv=%b required 1/deadbeef/0/0", instr_rvalid_o, instr_rdata_o, instr_err_o, data_rvalid_o);
        else pass_cnt++;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_data_store();
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'h3;
        data_addr_i  = 32'h100;
        data_wdata_i = 32'h1234_5678;
        #1;
        total_cnt++;
        if (data_gnt_o !== 1'b1 || instr_gnt_o !== 1'b0 || mem_req_o !== 1'b1 || mem_we_o !== 1'b1 ||
            mem_be_o !== 4'h3 || mem_addr_o !== 32'h100 || mem_wdata_o !== 32'h1234_5678)
            $display("FAIL store_req: dg=%b ig=%b req=%b we=%b be=%h addr=%h wdata=%h required 1/0/1/1/3/100/12345678",
                     data_gnt_o, instr_gnt_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        else pass_cnt++;
        tick();
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h0BAD_F00D;
        #1;
        total_cnt++;
        if (data_rvalid_o !== 1'b1 || data_rdata_o !== 32'h0BAD_F00D || data_err_o !== 1'b0 || instr_rvalid_o !== 1'b0)
            $display("FAIL store_resp: rv=%b rdata=%h err=%b irv=%b required 1/0badf00d/0/0", data_rvalid_o, data_rdata_o, data_err_o, instr_rvalid_o);
        else pass_cnt++;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_out_of_range();
        data_req_i   = 1'b1;
        data_we_i    = 1'b1;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h2000;
        data_wdata_i = 32'hCAFE_0000;
        #1;
        total_cnt++;
        if (data_gnt_o !== 1'b1 || mem_req_o !== 1'b0)
            $display("FAIL oor_gnt: dg=%b mem_req=%b required 1/0", data_gnt_o, mem_req_o);
        else pass_cnt++;
        tick();
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h5555_AAAA;
        #1;
        total_cnt++;
        if (data_rvalid_o !== 1'b1 || data_err_o !== 1'b1 || data_rdata_o !== 32'h0 || instr_rvalid_o !== 1'b0)
            $display("FAIL oor_resp: rv=%b err=%b rdata=%h irv=%b required 1/1/0/0", data_rvalid_o, data_err_o, data_rdata_o, instr_rvalid_o);
        else pass_cnt++;
        tick();
        mem_rvalid_i = 1'b0;
        #1;
        total_cnt++;
        if (data_rvalid_o !== 1'b0 || data_err_o !== 1'b0)
            $display("FAIL oor_clear: rv=%b err=%b required 0/0", data_rvalid_o, data_err_o);
        else pass_cnt++;
    endtask

    // Both ports request every cycle; expected grants I,I,I,I,D repeating.
    task automatic run_starve(input string tag, input int cycles);
        bit prev_d = 1'b0;
        bit prev_any = 1'b0;
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0;
        data_req_i   = 1'b1;
        data_we_i    = 1'b0;
        data_be_i    = 4'hF;
        data_addr_i  = 32'h40;
        for (int c = 0; c < cycles; c++) begin
            bit exp_d;
            exp_d        = ((c % 5) == 4);
            mem_rvalid_i = prev_any;
            mem_rdata_i  = 32'h100 + c;
            #1;
            total_cnt++;
            if (instr_gnt_o !== !exp_d || data_gnt_o !== exp_d)
                $display("FAIL %s_gnt[%0d]: ig=%b dg=%b required %b/%b", tag, c, instr_gnt_o, data_gnt_o, !exp_d, exp_d);
            else pass_cnt++;
            if (prev_any) begin
                total_cnt++;
                if (data_rvalid_o !== prev_d || instr_rvalid_o !== !prev_d)
                    $display("FAIL %s_rv[%0d]: irv=%b drv=%b required %b/%b", tag, c, instr_rvalid_o, data_rvalid_o, !prev_d, prev_d);
                else pass_cnt++;
            end
            prev_d   = exp_d;
            prev_any = 1'b1;
            tick();
        end
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h77;
        #1;
        total_cnt++;
        if (data_rvalid_o !== prev_d || instr_rvalid_o !== !prev_d)
            $display("FAIL %s_rv_last: irv=%b drv=%b required %b/%b", tag, instr_rvalid_o, data_rvalid_o, !prev_d, prev_d);
        else pass_cnt++;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_starvation();
        run_starve("starve", 10);
    endtask

    task automatic test_back_to_back();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h0;
        #1;
        total_cnt++;
        if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h0 || mem_req_o !== 1'b1)
            $display("FAIL b2b_gnt0: gnt=%b addr=%h req=%b required 1/0/1", instr_gnt_o, mem_addr_o, mem_req_o);
        else pass_cnt++;
        tick();
        instr_addr_i = 32'h4;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h1111_0000;
        #1;
        total_cnt++;
        if (instr_gnt_o !== 1'b1 || mem_addr_o !== 32'h4 || instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h1111_0000)
            $display("FAIL b2b_1: gnt=%b addr=%h rv=%b rdata=%h required 1/4/1/11110000", instr_gnt_o, mem_addr_o, instr_rvalid_o, instr_rdata_o);
        else pass_cnt++;
        tick();
        instr_req_i = 1'b0;
        mem_rdata_i = 32'h2222_0004;
        #1;
        total_cnt++;
        if (instr_rvalid_o !== 1'b1 || instr_rdata_o !== 32'h2222_0004)
            $display("FAIL b2b_2: rv=%b rdata=%h required 1/22220004", instr_rvalid_o, instr_rdata_o);
        else pass_cnt++;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_spurious_rvalid();
        idle_inputs();
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'hFFFF_FFFF;
        #1;
        total_cnt++;
        if (instr_rvalid_o !== 1'b0 || data_rvalid_o !== 1'b0 || instr_rdata_o !== 32'h0 || data_rdata_o !== 32'h0)
            $display("FAIL spurious: irv=%b drv=%b ird=%h drd=%h required 0/0/0/0", instr_rvalid_o, data_rvalid_o, instr_rdata_o, data_rdata_o);
        else pass_cnt++;
        total_cnt++;
        if (mem_req_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_be_o !== 4'h0)
            $display("FAIL idle_mem: req=%b addr=%h be=%h required 0/0/0", mem_req_o, mem_addr_o, mem_be_o);
        else pass_cnt++;
        tick();
        mem_rvalid_i = 1'b0;
    endtask

    task automatic test_reset_in_resp();
        data_req_i  = 1'b1;
        data_be_i   = 4'hF;
        data_addr_i = 32'h200;
        tick();
        instr_req_i  = 1'b1;
        instr_addr_i = 32'h8;
        mem_rvalid_i = 1'b1;
        mem_rdata_i  = 32'h3333_3333;
        #1;
        total_cnt++;
        if (data_rvalid_o !== 1'b1 || instr_gnt_o !== 1'b1)
            $display("FAIL rstd_pre: drv=%b ig=%b required 1/1", data_rvalid_o, instr_gnt_o);
        else pass_cnt++;
        rst_sys_n = 1'b0;
        #1;
        total_cnt++;
        if (data_rvalid_o !== 1'b0 || instr_gnt_o !== 1'b0 || mem_req_o !== 1'b0)
            $display("FAIL rstd_async: drv=%b ig=%b req=%b required 0/0/0", data_rvalid_o, instr_gnt_o, mem_req_o);
        else pass_cnt++;
        tick();
        idle_inputs();
        rst_sys_n    = 1'b1;
        mem_rvalid_i = 1'b1;
        tick();
        total_cnt++;
        if (data_rvalid_o !== 1'b0 || instr_rvalid_o !== 1'b0)
            $display("FAIL rstd_post: drv=%b irv=%b required 0/0", data_rvalid_o, instr_rvalid_o);
        else pass_cnt++;
        mem_rvalid_i = 1'b0;
        run_starve("rstcnt", 5);
    endtask

    initial begin
        test_reset();
        test_instr_fetch();
        test_data_store();
        test_out_of_range();
        test_starvation();
        test_back_to_back();
        test_spurious_rvalid();
        test_reset_in_resp();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
